// File: rtl/seq_and_reduce_pkg.sv
// Shared types and helpers for the folded AND/NAND reduction block.
// The optional early-exit feature is selected by SEQ_AND_REDUCE_EARLY_EXIT_EN.
package seq_and_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] SUPPLY_ON = 2'b10;

  function automatic int nslice(input int inputWidth, input int sliceWidth);
    return (inputWidth + sliceWidth - 1) / sliceWidth;
  endfunction

endpackage

// File: rtl/seq_and_reduce_slice.sv
// Combinational AND of one SLICE_WIDTH-bit slice down to a single bit.
module and_slice_reduce #(
  parameter int SLICE_WIDTH = 4
) (
  input  logic [SLICE_WIDTH-1:0] slice,
  output logic                   result
);

  assign result = &slice;

endmodule

// File: rtl/seq_and_reduce.sv
// Multi-channel AND/NAND reduction folded SLICE_WIDTH bits per cycle with valid/ready handshakes.
// Define SEQ_AND_REDUCE_EARLY_EXIT_EN to finish as soon as every channel accumulator is zero.
module seq_and_reduce
  import seq_and_reduce_pkg::*;
#(
  parameter int INPUT_WIDTH   = 16,
  parameter int SLICE_WIDTH   = 4,
  parameter int CHANNELS      = 2,
  parameter int INVERT_OUTPUT = 0
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic [1:0]                      DigitSupply,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic [CHANNELS*INPUT_WIDTH-1:0] inputData,
  output logic                            outValid,
  input  logic                            outReady,
  output logic [CHANNELS-1:0]             outputData,
  output logic                            busy
);

  localparam int NSLICE = nslice(INPUT_WIDTH, SLICE_WIDTH);
  localparam int PAD_W  = NSLICE * SLICE_WIDTH;
  localparam int CNT_W  = $clog2(NSLICE + 1);
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(NSLICE - 1);
  localparam logic [PAD_W-1:0]    FILL     = ~({PAD_W{1'b1}} >> SLICE_WIDTH);
  localparam logic [CHANNELS-1:0] INV_MASK = {CHANNELS{INVERT_OUTPUT != 0}};

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [CHANNELS-1:0]             acc;
  logic [CHANNELS-1:0]             accNext;
  logic [CHANNELS-1:0]             sliceAnd;
  logic [CHANNELS-1:0][PAD_W-1:0]  shiftReg;
  logic [CHANNELS-1:0][PAD_W-1:0]  loadVal;
  logic                            powered;
  logic                            accept;
  logic                            finish;

  assign powered = (DigitSupply == SUPPLY_ON);
  assign inReady = (state == IDLE) && powered;
  assign busy    = (state != IDLE);
  assign accept  = inValid && inReady;

  // Capture: each channel padded with ones above its operand bits
  always_comb begin
    loadVal = '1;
    for (int c = 0; c < CHANNELS; c++) begin
      loadVal[c][INPUT_WIDTH-1:0] = inputData[c*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  // Operand copy is pure data: no reset, consumed low slice first
  always_ff @(posedge Clock) begin
    if (accept) begin
      shiftReg <= loadVal;
    end else if (state == REDUCE) begin
      for (int c = 0; c < CHANNELS; c++) begin
        shiftReg[c] <= (shiftReg[c] >> SLICE_WIDTH) | FILL;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : gChan
    and_slice_reduce #(.SLICE_WIDTH(SLICE_WIDTH)) uSlice (
      .slice (shiftReg[c][SLICE_WIDTH-1:0]),
      .result(sliceAnd[c])
    );
  end

  assign accNext = acc & sliceAnd;

`ifdef SEQ_AND_REDUCE_EARLY_EXIT_EN
  assign finish = (cnt == LAST_CNT) || (accNext == '0);
`else
  assign finish = (cnt == LAST_CNT);
`endif

  // Control FSM; losing supply behaves like a synchronous reset
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '1;
      outValid   <= 1'b0;
      outputData <= '0;
    end else if (!powered) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '1;
      outValid   <= 1'b0;
      outputData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            state <= REDUCE;
            acc   <= '1;
            cnt   <= '0;
          end
        end
        REDUCE: begin
          acc <= accNext;
          cnt <= cnt + 1'b1;
          if (finish) begin
            state      <= DONE;
            outValid   <= 1'b1;
            outputData <= accNext ^ INV_MASK;
          end
        end
        DONE: begin
          if (outReady) begin
            state    <= IDLE;
            outValid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_and_reduce.sv
// Directed bench for seq_and_reduce: 16x2 AND, 16x2 NAND (lockstep) and 10-bit single channel.
module tb_seq_and_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  supply;

  logic        inValidA, outReadyA;
  logic [31:0] dataA;
  logic        inReadyA, outValidA, busyA;
  logic [1:0]  outDataA;
  logic        inReadyC, outValidC, busyC;
  logic [1:0]  outDataC;

  logic        inValidB, outReadyB;
  logic [9:0]  dataB;
  logic        inReadyB, outValidB, busyB;
  logic [0:0]  outDataB;

  int errCnt = 0;
  int chkCnt = 0;

`ifdef SEQ_AND_REDUCE_EARLY_EXIT_EN
  localparam int LAT_MIXED = 2;
  localparam int LAT_ZERO  = 1;
`else
  localparam int LAT_MIXED = 4;
  localparam int LAT_ZERO  = 4;
`endif

  always #5 clk = ~clk;

  seq_and_reduce #(.INPUT_WIDTH(16), .SLICE_WIDTH(4), .CHANNELS(2), .INVERT_OUTPUT(0)) dutA (
    .Clock(clk), .Reset(rst), .DigitSupply(supply),
    .inValid(inValidA), .inReady(inReadyA), .inputData(dataA),
    .outValid(outValidA), .outReady(outReadyA), .outputData(outDataA), .busy(busyA)
  );

  seq_and_reduce #(.INPUT_WIDTH(16), .SLICE_WIDTH(4), .CHANNELS(2), .INVERT_OUTPUT(1)) dutC (
    .Clock(clk), .Reset(rst), .DigitSupply(supply),
    .inValid(inValidA), .inReady(inReadyC), .inputData(dataA),
    .outValid(outValidC), .outReady(outReadyA), .outputData(outDataC), .busy(busyC)
  );

  seq_and_reduce #(.INPUT_WIDTH(10), .SLICE_WIDTH(4), .CHANNELS(1), .INVERT_OUTPUT(0)) dutB (
    .Clock(clk), .Reset(rst), .DigitSupply(supply),
    .inValid(inValidB), .inReady(inReadyB), .inputData(dataB),
    .outValid(outValidB), .outReady(outReadyB), .outputData(outDataB), .busy(busyB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic runA(input logic [31:0] d, output int lat, output logic [1:0] res,
                      output logic [1:0] resC);
    @(negedge clk);
    dataA    = d;
    inValidA = 1'b1;
    @(negedge clk);
    inValidA = 1'b0;
    dataA    = ~d;
    lat = 0;
    while (!outValidA && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res  = outDataA;
    resC = outDataC;
  endtask

  task automatic popA;
    outReadyA = 1'b1;
    @(negedge clk);
    outReadyA = 1'b0;
  endtask

  task automatic runB(input logic [9:0] d, output int lat, output logic res);
    @(negedge clk);
    dataB    = d;
    inValidB = 1'b1;
    @(negedge clk);
    inValidB = 1'b0;
    dataB    = ~d;
    lat = 0;
    while (!outValidB && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = outDataB[0];
    @(negedge clk);
  endtask

  initial begin
    int          lat;
    logic [1:0]  res, resC;
    logic        resB;
    logic        seen;

    rst = 1'b1; supply = 2'b10;
    inValidA = 1'b0; outReadyA = 1'b0; dataA = '0;
    inValidB = 1'b0; outReadyB = 1'b1; dataB = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_inReady", inReadyA, 1);
    check("rst_outValid", outValidA, 0);
    check("rst_outData", outDataA, 0);
    check("rst_busy", busyA, 0);

    runA(32'hFFFF_FFFF, lat, res, resC);
    check("ones_lat", lat, 4);
    check("ones_data", res, 2'b11);
    popA();

    runA({16'hFFEF, 16'hFFFF}, lat, res, resC);
    check("mix_lat", lat, 4);
    check("mix_data", res, 2'b01);
    check("mix_nand", resC, 2'b10);

    // backpressure: result held while consumer stalls
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!outValidA || outDataA != 2'b01 || inReadyA || !busyA) seen = 1'b1;
    end
    check("bp_stable", seen, 0);
    check("bp_inReady", inReadyA, 0);
    popA();
    check("pop_outValid", outValidA, 0);
    check("pop_inReady", inReadyA, 1);
    check("pop_hold", outDataA, 2'b01);

    runB(10'h3FF, lat, resB);
    check("w10_ones_lat", lat, 3);
    check("w10_ones_data", resB, 1);
    runB(10'h1FF, lat, resB);
    check("w10_bit9_lat", lat, 3);
    check("w10_bit9_data", resB, 0);

    runA({16'h00F0, 16'h000F}, lat, res, resC);
    check("early_lat", lat, LAT_MIXED);
    check("early_data", res, 2'b00);
    popA();
    runA(32'h0000_0000, lat, res, resC);
    check("zero_lat", lat, LAT_ZERO);
    check("zero_data", res, 2'b00);
    check("zero_nand", resC, 2'b11);
    popA();

    // outputData is non-zero again before the mid-REDUCE reset
    runA(32'hFFFF_FFFF, lat, res, resC);
    check("pre_rst_data", res, 2'b11);
    popA();

    @(negedge clk);
    dataA = 32'hFFFF_FFFF; inValidA = 1'b1;
    @(negedge clk);
    inValidA = 1'b0;
    @(negedge clk);
    check("mid_busy", busyA, 1);
    #2 rst = 1'b1;
    #1 check("arst_outData", outDataA, 0);
    check("arst_busy", busyA, 0);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (outValidA) seen = 1'b1;
    end
    check("arst_noValid", seen, 0);
    check("arst_inReady", inReadyA, 1);
    runA(32'hFFFF_FFFF, lat, res, resC);
    check("arst_after_lat", lat, 4);
    check("arst_after_data", res, 2'b11);
    popA();

    @(negedge clk);
    dataA = 32'hFFFF_FFFF; inValidA = 1'b1;
    @(negedge clk);
    inValidA = 1'b0;
    @(negedge clk);
    supply = 2'b00;
    @(negedge clk);
    check("pwr_inReady", inReadyA, 0);
    check("pwr_busy", busyA, 0);
    check("pwr_outData", outDataA, 0);
    @(negedge clk);
    supply = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (outValidA) seen = 1'b1;
    end
    check("pwr_noValid", seen, 0);
    runA(32'hFFFF_FFFF, lat, res, resC);
    check("pwr_after_lat", lat, 4);
    check("pwr_after_data", res, 2'b11);
    popA();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
